// File: rtl/wallace_mul_arbiter.sv
// wallace_mul_arbiter: two requesters share one 6x6 Wallace multiplier.
// Round-robin arbitration feeds a two-stage pipeline. S1 holds the two
// carry-save rows from the reduction tree. S2 holds the final product.
// Optional build macro: WALLACE_ARB_STATS_EN adds the grant_cnt0 and
// grant_cnt1 saturating transfer counters.
module wallace_mul_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [5:0]  req0_a,
  input  logic [5:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [5:0]  req1_a,
  input  logic [5:0]  req1_b,
  output logic        req1_ready,
  output logic        out_valid,
  output logic        out_id,
  output logic [11:0] out_product,
  input  logic        out_ready,
  output logic        busy
`ifdef WALLACE_ARB_STATS_EN
  ,
  output logic [7:0]  grant_cnt0,
  output logic [7:0]  grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  // One 3:2 compressor layer applied across a whole 12-bit row.
  typedef struct packed {
    logic [11:0] s;
    logic [11:0] c;
  } csa_t;

  // The carry out of bit 11 is dropped. The product is below 4096, so the
  // final sum modulo 2^12 is still exact.
  function automatic csa_t csa(input logic [11:0] x,
                               input logic [11:0] y,
                               input logic [11:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = {((x[10:0] & y[10:0]) | (x[10:0] & z[10:0]) | (y[10:0] & z[10:0])), 1'b0};
    return r;
  endfunction

  state_t      state;
  state_t      state_nxt;

  logic        last_grant;
  logic        win;
  logic        xfer;
  logic        s2_adv;
  logic        s1_accept;

  logic        s1_valid;
  logic        s1_id;
  logic [11:0] s1_r1;
  logic [11:0] s1_r2;
  logic        s1_valid_nxt;
  logic        s2_valid_nxt;
  logic        pipe_live;

  logic [5:0]  op_a;
  logic [5:0]  op_b;
  logic [11:0] pp0, pp1, pp2, pp3, pp4, pp5;
  csa_t        l1a, l1b, l2, l3;
  logic [11:0] r1;
  logic [11:0] r2;

  // Round-robin winner. With both requesters valid, the one not granted
  // last wins. Otherwise the single valid requester wins.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) begin
      win = ~last_grant;
    end else begin
      win = req1_valid;
    end
  end

  // Handshake. Ready is suppressed while rst is held so that reset clears it.
  always_comb begin
    s2_adv     = ~out_valid | out_ready;
    s1_accept  = ~s1_valid | s2_adv;
    req0_ready = ~rst & req0_valid & ~win & s1_accept;
    req1_ready = ~rst & req1_valid &  win & s1_accept;
    xfer       = req0_ready | req1_ready;
  end

  // Operand mux in front of the shared tree, then the partial products.
  always_comb begin
    op_a = win ? req1_a : req0_a;
    op_b = win ? req1_b : req0_b;
    pp0  = op_b[0] ? {6'b0, op_a}        : '0;
    pp1  = op_b[1] ? {5'b0, op_a, 1'b0}  : '0;
    pp2  = op_b[2] ? {4'b0, op_a, 2'b0}  : '0;
    pp3  = op_b[3] ? {3'b0, op_a, 3'b0}  : '0;
    pp4  = op_b[4] ? {2'b0, op_a, 4'b0}  : '0;
    pp5  = op_b[5] ? {1'b0, op_a, 5'b0}  : '0;
  end

  // Wallace reduction: 6 rows -> 4 -> 3 -> 2 (R1, R2).
  always_comb begin
    l1a = csa(pp0, pp1, pp2);
    l1b = csa(pp3, pp4, pp5);
    l2  = csa(l1a.s, l1a.c, l1b.s);
    l3  = csa(l2.s, l2.c, l1b.c);
    r1  = l3.s;
    r2  = l3.c;
  end

  // Stage occupancy after the coming edge. S1 reloads on a transfer and
  // drains when S2 advances. S2 takes S1 whenever it advances.
  always_comb begin
    s1_valid_nxt = xfer | (s1_valid & ~s2_adv);
    s2_valid_nxt = s2_adv ? s1_valid : out_valid;
    pipe_live    = s1_valid_nxt | s2_valid_nxt;
  end

  // Pipeline registers and the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_id       <= 1'b0;
      s1_r1       <= '0;
      s1_r2       <= '0;
      out_valid   <= 1'b0;
      out_id      <= 1'b0;
      out_product <= '0;
      last_grant  <= 1'b1;
    end else begin
      s1_valid  <= s1_valid_nxt;
      out_valid <= s2_valid_nxt;
      if (s2_adv && s1_valid) begin
        out_product <= s1_r1 + s1_r2;
        out_id      <= s1_id;
      end
      if (xfer) begin
        s1_r1      <= r1;
        s1_r2      <= r2;
        s1_id      <= win;
        last_grant <= win;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control next state. Leaving STALL goes straight to IDLE when the popped
  // entry was the last one, so busy always means "some stage is valid".
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (xfer) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (out_valid && !out_ready) state_nxt = STALL;
        else if (!pipe_live)         state_nxt = IDLE;
      end
      STALL: begin
        if (out_ready) state_nxt = pipe_live ? ACTIVE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef WALLACE_ARB_STATS_EN
  // Per-requester transfer counters, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 8'd1;
      if (req1_ready && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Self-checking bench for wallace_mul_arbiter. A queue-based model of
// in-flight operations is compared against the DUT on every falling edge.
// Directed scenarios then pin the model with hand-computed results.
module tb_wallace_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0;
  logic [5:0]  req0_a = '0;
  logic [5:0]  req0_b = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [5:0]  req1_a = '0;
  logic [5:0]  req1_b = '0;
  logic        req1_ready;
  logic        out_valid;
  logic        out_id;
  logic [11:0] out_product;
  logic        out_ready = 1'b1;
  logic        busy;
`ifdef WALLACE_ARB_STATS_EN
  logic [7:0]  grant_cnt0;
  logic [7:0]  grant_cnt1;
`endif

  wallace_mul_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ready  (req1_ready),
    .out_valid   (out_valid),
    .out_id      (out_id),
    .out_product (out_product),
    .out_ready   (out_ready),
    .busy        (busy)
`ifdef WALLACE_ARB_STATS_EN
    ,
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: in-flight operations in issue order. at_out marks the one
  // presented on the output.
  typedef struct {
    bit id;
    int prod;
    bit at_out;
  } op_t;

  op_t q[$];
  bit  mptr = 1'b1;
  bit  m_ov, m_s1, m_adv, m_can, m_win, e_r0, e_r1;
  op_t t_op;

  int  cyc = 0;
  int  n_xfer = 0;
  int  last_xfer_cyc = 0;
  int  lat_dut = -1;
  bit  prev_ov = 1'b0;
  int  pop_log[$];
  int  pid_log[$];
  int  grant_log[$];
  int  grant_cyc[$];
  int  exp_q[$];

  // Compare process: check the DUT against the model, then step the model
  // to where it must be after the coming rising edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_product", out_product, 0);
      chk("rst_out_id", out_id, 0);
      q.delete();
      mptr    = 1'b1;
      prev_ov = 1'b0;
    end else begin
      m_ov  = (q.size() > 0) && q[0].at_out;
      m_s1  = (q.size() > 0) && !q[q.size()-1].at_out;
      m_adv = !m_ov || out_ready;
      m_can = !m_s1 || m_adv;
      m_win = (req0_valid && req1_valid) ? !mptr : req1_valid;
      e_r0  = req0_valid && !m_win && m_can;
      e_r1  = req1_valid &&  m_win && m_can;

      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("out_valid", out_valid, m_ov);
      chk("busy", busy, (q.size() > 0) ? 1 : 0);
      if (m_ov) begin
        chk("out_product", out_product, q[0].prod);
        chk("out_id", out_id, q[0].id);
      end

      if (out_valid && !prev_ov) lat_dut = cyc - last_xfer_cyc;
      prev_ov = out_valid;
      if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) begin
        grant_log.push_back(req1_ready ? 1 : 0);
        grant_cyc.push_back(cyc);
        last_xfer_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        pop_log.push_back(int'(out_product));
        pid_log.push_back(int'(out_id));
      end

      if (m_ov && out_ready) void'(q.pop_front());
      if (m_adv && q.size() > 0) begin
        t_op = q[0];
        t_op.at_out = 1'b1;
        q[0] = t_op;
      end
      if (e_r0) begin
        q.push_back('{id: 1'b0, prod: int'(req0_a) * int'(req0_b), at_out: 1'b0});
        mptr = 1'b0;
        n_xfer++;
      end else if (e_r1) begin
        q.push_back('{id: 1'b1, prod: int'(req1_a) * int'(req1_b), at_out: 1'b0});
        mptr = 1'b1;
        n_xfer++;
      end
    end
  end

  logic [5:0] a0[8], b0[8], a1[8], b1[8];

  // Stream operand lists from both requesters. Each pair is held until its
  // own transfer.
  task automatic run_streams(input int n0, input int n1, input int budget);
    int i0 = 0;
    int i1 = 0;
    int t  = 0;
    bit r0, r1;
    while ((i0 < n0 || i1 < n1) && t < budget) begin
      req0_valid = (i0 < n0);
      req0_a = a0[i0[2:0]];
      req0_b = b0[i0[2:0]];
      req1_valid = (i1 < n1);
      req1_a = a1[i1[2:0]];
      req1_b = b1[i1[2:0]];
      @(negedge clk);
      r0 = req0_valid && req0_ready;
      r1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (r0) i0++;
      if (r1) i1++;
      t++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("stream_complete", ((i0 >= n0) && (i1 >= n1)) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    @(negedge clk);
    while ((busy || out_valid) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", (t < budget) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_log.delete();
    pid_log.delete();
    grant_log.delete();
    grant_cyc.delete();
    lat_dut = -1;
  endtask

  task automatic chk_log(input string name, input int sel);
    int got[$];
    if (sel == 0)      got = pop_log;
    else if (sel == 1) got = pid_log;
    else               got = grant_log;
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(name, got[i], exp_q[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int base;

  initial begin
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_busy", busy, 0);

    // Single op right after reset: 5*7 = 35, id 0, latency 2.
    clear_logs();
    out_ready = 1'b1;
    a0[0] = 6'd5; b0[0] = 6'd7;
    run_streams(1, 0, 10);
    wait_idle(10);
    exp_q = '{35}; chk_log("single_prod", 0);
    exp_q = '{0};  chk_log("single_id", 1);
    chk("single_latency", lat_dut, 2);

    // Contention: both requesters valid continuously, from reset.
    do_reset();
    clear_logs();
    a0[0] = 6'd3; b0[0] = 6'd3; a0[1] = 6'd3; b0[1] = 6'd3;
    a1[0] = 6'd4; b1[0] = 6'd4; a1[1] = 6'd4; b1[1] = 6'd4;
    run_streams(2, 2, 20);
    wait_idle(10);
    exp_q = '{0, 1, 0, 1};   chk_log("cont_grants", 2);
    exp_q = '{9, 16, 9, 16}; chk_log("cont_prod", 0);
    exp_q = '{0, 1, 0, 1};   chk_log("cont_id", 1);
    if (grant_cyc.size() == 4) chk("cont_back_to_back", grant_cyc[3] - grant_cyc[0], 3);
    else chk("cont_grant_cnt", grant_cyc.size(), 4);

    // Backpressure: out_ready low for 5 cycles while req0 streams 1,2,3 squared.
    do_reset();
    clear_logs();
    a0[0] = 6'd1; b0[0] = 6'd1; a0[1] = 6'd2; b0[1] = 6'd2; a0[2] = 6'd3; b0[2] = 6'd3;
    out_ready = 1'b0;
    base = n_xfer;
    fork
      run_streams(3, 0, 30);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_transfers", n_xfer - base, 2);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_prod", out_product, 1);
        out_ready = 1'b1;
      end
    join
    wait_idle(10);
    exp_q = '{1, 4, 9}; chk_log("bp_prod", 0);

    // Operands that change while stalled must be ignored.
    do_reset();
    clear_logs();
    out_ready = 1'b0;
    a0[0] = 6'd1; b0[0] = 6'd2; a0[1] = 6'd3; b0[1] = 6'd4;
    run_streams(2, 0, 10);
    base = n_xfer;
    for (int k = 0; k < 3; k++) begin
      req1_valid = 1'b1;
      req1_a = 6'(7 * k + 3);
      req1_b = 6'(11 * k + 9);
      @(posedge clk);
      #1;
    end
    chk("stall_no_xfer", n_xfer - base, 0);
    a1[0] = 6'd5; b1[0] = 6'd5;
    out_ready = 1'b1;
    run_streams(0, 1, 10);
    wait_idle(10);
    exp_q = '{2, 12, 25}; chk_log("stall_prod", 0);
    exp_q = '{0, 0, 1};   chk_log("stall_id", 1);

    // Extremes.
    clear_logs();
    a0[0] = 6'd63; b0[0] = 6'd63; a0[1] = 6'd0; b0[1] = 6'd63; a0[2] = 6'd63; b0[2] = 6'd1;
    run_streams(3, 0, 10);
    wait_idle(10);
    exp_q = '{3969, 0, 63}; chk_log("ext_prod", 0);

    // Reset one cycle after a transfer drops the operation.
    clear_logs();
    a0[0] = 6'd5; b0[0] = 6'd5;
    run_streams(1, 0, 10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmid_out_valid", out_valid, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_no_pop", pop_log.size(), 0);
    @(posedge clk);
    #1;
    clear_logs();
    a1[0] = 6'd6; b1[0] = 6'd7;
    run_streams(0, 1, 10);
    wait_idle(10);
    exp_q = '{42}; chk_log("rmid_prod", 0);
    exp_q = '{1};  chk_log("rmid_id", 1);
    chk("rmid_latency", lat_dut, 2);

`ifdef WALLACE_ARB_STATS_EN
    // 300 transfers from requester 1: its counter saturates.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a1[i] = 6'd1;
      b1[i] = 6'd1;
    end
    run_streams(0, 300, 400);
    wait_idle(10);
    chk("stats_cnt1", grant_cnt1, 255);
    chk("stats_cnt0", grant_cnt0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wallace_mul_arbiter.md
WALLACE_MUL_ARBITER -- requirements
Module: wallace_mul_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The port list SHALL be, with the clock and reset first, as follows:
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a, req0_b  in  6 each  requester 0 operands (unsigned)
- req0_ready  out  1  requester 0 pair accepted this cycle
- req1_valid  in  1  requester 1 has an operand pair
- req1_a, req1_b  in  6 each  requester 1 operands (unsigned)
- req1_ready  out  1  requester 1 pair accepted this cycle
- out_valid  out  1  product available
- out_id  out  1  requester index of the product
- out_product  out  12  unsigned product a*b
- out_ready  in  1  consumer accepts the product
- busy  out  1  a pipeline stage holds a valid operation

Function
REQ-003 The block SHALL share one 6x6 Wallace reduction tree (A,B -> R1,R2) between the two requesters.
REQ-004 The pipeline SHALL have two stages.
- S1 register: captures R1, R2 and the requester id at grant.
- S2 register: holds R1+R2 (12-bit, carry-out discarded) as out_product, with out_id.
REQ-005 A transfer SHALL occur when reqN_valid and reqN_ready are both high on a clock edge.
REQ-006 At most one of req0_ready and req1_ready SHALL be high in a cycle.
REQ-007 reqN_ready SHALL be high only when reqN_valid is high, N is the arbitration winner, and S1 can accept.
REQ-008 S1 SHALL be able to accept when it is empty, or when its contents advance to S2 on the same edge.
REQ-009 S2 SHALL advance (load from S1 or go empty) when out_valid is 0 or out_ready is 1.
- If S2 does not advance, S1 and S2 SHALL both hold their contents.
REQ-010 Arbitration SHALL be round-robin using a 1-bit last-grant pointer.
- Both requesters valid: the requester other than the last granted wins.
- One requester valid: that requester wins.
- The pointer SHALL update only on a transfer.
REQ-011 Latency from transfer to out_valid SHALL be exactly 2 cycles when there is no backpressure.
REQ-012 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-013 While out_valid=1 and out_ready=0, out_product and out_id SHALL be stable, and no transfer SHALL be lost or duplicated.
REQ-014 The control FSM SHALL have the following states and transitions:
- IDLE: no valid stage. Goes to ACTIVE on a transfer.
- ACTIVE: at least one valid stage, no stall. Goes to STALL when out_valid=1 and out_ready=0. Goes to IDLE when the last operation leaves and there is no new transfer.
- STALL: goes to ACTIVE when out_ready=1.
REQ-015 busy SHALL be 1 in the ACTIVE and STALL states.
REQ-016 The following boundary cases SHALL behave as stated:
- Simultaneous output pop and new grant with both stages full: S2 takes S1 and S1 takes the new pair, with no bubble.
- Operands 63*63 SHALL give 3969.
- Operands 0*x SHALL give 0.
REQ-017 Requester inputs SHALL be sampled only on a transfer edge; changes to operands while valid is high and ready is low SHALL have no effect.

Reset
REQ-018 Asserting rst SHALL immediately clear the following:
- S1 and S2 valid flags
- out_valid, busy, req0_ready, req1_ready to 0
- out_product and out_id to 0
- the pointer to 1, so that requester 0 wins first
- the FSM to IDLE
REQ-019 Any reset asserted mid-operation SHALL discard in-flight operations with no output.
REQ-020 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-021 Macro WALLACE_ARB_STATS_EN SHALL control the statistics outputs.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (out, 8 bits each). Each counts transfers for its requester, saturates at 255, and resets to 0.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

Verification
REQ-022 Directed scenarios SHALL cover the following (stimulus -> required response):
- Single op: req0 5*7, out_ready=1 -> 2 cycles later out_valid=1, out_product=35, out_id=0.
- Contention: both requesters valid continuously (req0 3*3, req1 4*4) after reset -> grants alternate 0,1,0,1; outputs 9,16,9,16.
- Backpressure: out_ready=0 for 5 cycles while req0 streams 1*1, 2*2, 3*3 -> only 2 transfers; out_product=1 held; after release, outputs 1,4,9 in order with no loss.
- Extremes: 63*63 -> 3969; 0*63 -> 0; 63*1 -> 63.
- Reset mid-flight: rst pulse one cycle after a transfer -> no out_valid; busy=0; next req1 is granted normally with 2-cycle latency.
- Stats (WALLACE_ARB_STATS_EN): 300 transfers from req1 -> grant_cnt1=255, grant_cnt0=0.
